pipelined_chunk_adder: RTL

- Parametrised WIDTH-bit adder/subtractor, built as a ripple-carry chain cut into CHUNK-bit pipeline stages.
- Each stage is one registered slice of full-adder cells. The carry is registered between stages, and operand and result bits are skewed and deskewed so every result word comes out aligned.
- Valid/ready handshake on input and output, so it drops into streaming datapaths as the arithmetic primitive above the single-bit full adder.

---
 rtl/pipelined_chunk_adder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipelined_chunk_adder.sv
// Pipelined ripple-carry adder/subtractor, CHUNK bits per stage, valid/ready.
// Optional macro PIPE_ADD_OVF_EN adds a pipelined signed-overflow flag (ovf).
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = (CHUNK < 1) ? 1 : WIDTH / CHUNK;
  localparam int L      = STAGES - 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK >= 1");
  end

  // Skewed operands (upper slices still to add), deskewed partial sums,
  // inter-stage carries and per-stage valid flags.
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;

  logic [WIDTH-1:0]  w_ia [STAGES];
  logic [WIDTH-1:0]  w_ib [STAGES];
  logic [WIDTH-1:0]  w_is [STAGES];
  logic [WIDTH-1:0]  w_os [STAGES];
  logic [CHUNK:0]    w_part [STAGES];
  logic [STAGES-1:0] w_ic;
  logic [STAGES-1:0] w_iv;
  logic [STAGES-1:0] w_oc;

  logic             w_stall;
  logic [WIDTH-1:0] w_bp;
  logic             w_c0;

  assign w_bp     = sub ? ~b : b;
  assign w_c0     = sub | cin;
  assign w_stall  = r_v[L] & ~out_ready;
  assign in_ready = ~w_stall;

  // Per-stage slice add: stage k consumes slice k with the carry from k-1.
  always_comb begin
    w_ia[0] = a;
    w_ib[0] = w_bp;
    w_is[0] = '0;
    w_ic[0] = w_c0;
    w_iv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_ia[k] = r_a[k-1];
      w_ib[k] = r_b[k-1];
      w_is[k] = r_s[k-1];
      w_ic[k] = r_c[k-1];
      w_iv[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_part[k] = {1'b0, w_ia[k][k*CHUNK +: CHUNK]}
                + {1'b0, w_ib[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, w_ic[k]};
      w_os[k] = w_is[k];
      w_os[k][k*CHUNK +: CHUNK] = w_part[k][CHUNK-1:0];
      w_oc[k] = w_part[k][CHUNK];
    end
  end

  // Advance the whole pipeline unless the output word is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c <= '0;
      r_v <= '0;
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_ia[k];
        r_b[k] <= w_ib[k];
        r_s[k] <= w_os[k];
      end
      r_c <= w_oc;
      r_v <= w_iv;
    end
  end

  assign out_valid = r_v[L];
  assign sum       = r_s[L];
  assign cout      = r_c[L];

`ifdef PIPE_ADD_OVF_EN
  logic r_ovf;
  logic w_ovf;

  // Carry into the MSB is recovered as a^b'^s at that bit.
  assign w_ovf = w_ia[L][WIDTH-1] ^ w_ib[L][WIDTH-1]
               ^ w_os[L][WIDTH-1] ^ w_oc[L];

  // Overflow flag travels with the last stage and holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_stall) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
